// File: rtl/sprite_pkg.sv
// Shared sprite ROM constants: tile geometry, sprite ids, address field layout and the transparent pixel.
package sprite_pkg;

    localparam int TILE_PX = 32;

    localparam int TILE_X_W   = 5;
    localparam int TILE_Y_W   = 5;
    localparam int SPRITE_W   = 3;
    localparam int TILE_X_LSB = 0;
    localparam int TILE_Y_LSB = TILE_X_LSB + TILE_X_W;
    localparam int SPRITE_LSB = TILE_Y_LSB + TILE_Y_W;

    typedef enum logic [SPRITE_W-1:0] {
        BG    = 3'd0,
        FROG  = 3'd1,
        CAR   = 3'd2,
        LOG   = 3'd3,
        WATER = 3'd4,
        GOAL  = 3'd5
    } sprite_id_e;

    localparam logic [8:0] TRANSPARENT = 9'h000;

    // Six sprites of one 32x32 tile each are populated; higher sprite ids fall off the end.
    localparam int SPRITE_ROM_DEPTH = 6 * TILE_PX * TILE_PX;

    function automatic logic [SPRITE_W+TILE_Y_W+TILE_X_W-1:0] sprite_addr(
        input sprite_id_e          id,
        input logic [TILE_Y_W-1:0] y,
        input logic [TILE_X_W-1:0] x
    );
        return {id, y, x};
    endfunction

endpackage

// File: rtl/rr_pick.sv
// One-hot picker: grants the first set request found searching upward from start, wrapping modulo N.
module rr_pick
    import sprite_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int o = 0; o < N; o++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] && (((int'(start) + o) % N) == i)) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM read port among NUM_REQ pixel fetchers and returns tagged pixels.
// Define ROUND_ROBIN_EN for rotating priority; default build is fixed priority (index 0 highest).
module sprite_rom_arbiter
    import sprite_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int ADDR_W    = 13,
    parameter int DATA_W    = 9,
    parameter int ROM_DEPTH = SPRITE_ROM_DEPTH,
    parameter int ROM_LAT   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_start,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      rom_en,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      addr_err,
    output logic                      busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   start;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [ADDR_W-1:0]  sel_addr;
    logic               any_gnt;
    logic               miss;

    // Stage k holds the grant issued k+1 cycles earlier; the last stage lines up with rom_data.
    logic [NUM_REQ-1:0] tag_id   [ROM_LAT+1];
    logic               tag_miss [ROM_LAT+1];

    rr_pick #(.N(NUM_REQ), .IW(PTR_W)) u_pick (
        .req   (req),
        .start (start),
        .gnt   (pick_gnt)
    );

    // No grant may be seen while reset is held, even though the picker is purely combinational.
    assign gnt     = pick_gnt & {NUM_REQ{rst_n}};
    assign any_gnt = |gnt;

    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        end
    end

    assign miss = (int'(sel_addr) >= ROM_DEPTH);

`ifdef ROUND_ROBIN_EN
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win_idx;

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_gnt[i]) win_idx = PTR_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (frame_start) begin
            ptr <= '0;
        end else if (any_gnt) begin
            ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end
    end

    assign start = ptr;
`else
    assign start = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_en   <= 1'b0;
            rom_addr <= '0;
            addr_err <= 1'b0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_id[k]   <= '0;
                tag_miss[k] <= 1'b0;
            end
        end else begin
            rom_en <= any_gnt && !miss;
            if (any_gnt && !miss) rom_addr <= sel_addr;
            tag_id[0]   <= gnt;
            tag_miss[0] <= any_gnt && miss;
            for (int k = 1; k <= ROM_LAT; k++) begin
                tag_id[k]   <= tag_id[k-1];
                tag_miss[k] <= tag_miss[k-1];
            end
            // A miss in the same cycle as frame_start still sets the flag.
            addr_err <= (addr_err && !frame_start) || (any_gnt && miss);
        end
    end

    assign rsp_valid = tag_id[ROM_LAT];
    assign rsp_data  = (|tag_id[ROM_LAT] && !tag_miss[ROM_LAT]) ? rom_data : DATA_W'(TRANSPARENT);

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= ROM_LAT; k++) busy = busy | (|tag_id[k]);
    end

endmodule
